// File: rtl/packet_pkg.sv
// Shared packet widths, transmitter state encoding and address helpers
// for the switch port transmitter.
package packet_pkg;

   localparam int ADDR_WIDTH    = 4;
   localparam int PAYLOAD_WIDTH = 8;
   localparam int DATA_WIDTH    = PAYLOAD_WIDTH + 2 * ADDR_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } tx_state_e;

   // True when exactly one address bit is set.
   function automatic logic is_onehot(input logic [ADDR_WIDTH-1:0] v);
      return (v != '0) && ((v & (v - ADDR_WIDTH'(1))) == '0);
   endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous request queue with full/empty flags; the head entry is
// visible combinationally on o_rd_data while the queue is non-empty.
module tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push    = i_push && !o_full;
   assign w_pop     = i_pop && !o_empty;
   assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
      end
   end

endmodule

// File: rtl/port_tx.sv
// Switch port transmitter: queues host packets and emits one-cycle tx strobes
// separated by a fixed idle gap, discarding packets with unusable targets.
module port_tx
   import packet_pkg::*;
#(
   parameter int PORT_ID    = 0,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDR_WIDTH-1:0]    req_target,
   input  logic [PAYLOAD_WIDTH-1:0] req_data,
   output logic                     tx_valid,
   output logic [ADDR_WIDTH-1:0]    tx_source,
   output logic [ADDR_WIDTH-1:0]    tx_target,
   output logic [PAYLOAD_WIDTH-1:0] tx_data,
   output logic                     busy,
   output logic [15:0]              sent_cnt,
   output logic [7:0]               drop_cnt
);

   localparam int QW = ADDR_WIDTH + PAYLOAD_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] SRC_ADDR = ADDR_WIDTH'(1 << PORT_ID);
   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   tx_state_e                r_state;
   tx_state_e                w_next;
   logic [3:0]               r_gap_cnt;
   logic                     r_tx_valid;
   logic [ADDR_WIDTH-1:0]    r_tx_source;
   logic [ADDR_WIDTH-1:0]    r_tx_target;
   logic [PAYLOAD_WIDTH-1:0] r_tx_data;
   logic [15:0]              r_sent_cnt;
   logic [7:0]               r_drop_cnt;

   logic [QW-1:0]            w_head;
   logic [ADDR_WIDTH-1:0]    w_head_target;
   logic [PAYLOAD_WIDTH-1:0] w_head_data;
   logic                     w_fifo_full;
   logic                     w_fifo_empty;
   logic                     w_head_ok;
   logic                     w_pop_opp;
   logic                     w_pop;
   logic                     w_load;
   logic                     w_drop;

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (QW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push    (req_valid),
      .i_wr_data ({req_target, req_data}),
      .i_pop     (w_pop),
      .o_rd_data (w_head),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   assign w_head_target = w_head[QW-1:PAYLOAD_WIDTH];
   assign w_head_data   = w_head[PAYLOAD_WIDTH-1:0];
   assign w_head_ok     = is_onehot(w_head_target) && (w_head_target != SRC_ADDR);

   // Pop opportunities: IDLE, final GAP cycle, or SEND itself when there is no gap.
   always_comb begin
      w_pop_opp = 1'b0;
      w_next    = r_state;
      case (r_state)
         ST_IDLE: begin
            w_pop_opp = 1'b1;
         end
         ST_SEND: begin
            w_pop_opp = (GAP_CYCLES == 0);
            w_next    = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
         end
         ST_GAP: begin
            w_pop_opp = (r_gap_cnt == 4'd0);
            w_next    = (r_gap_cnt == 4'd0) ? ST_IDLE : ST_GAP;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
      w_pop = w_pop_opp && enable && !w_fifo_empty;
      if (w_pop) begin
         w_next = w_head_ok ? ST_SEND : ST_IDLE;
      end
   end

   assign w_load = w_pop && w_head_ok;
   assign w_drop = w_pop && !w_head_ok;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state     <= ST_IDLE;
         r_gap_cnt   <= 4'd0;
         r_tx_valid  <= 1'b0;
         r_tx_source <= '0;
         r_tx_target <= '0;
         r_tx_data   <= '0;
         r_sent_cnt  <= 16'd0;
         r_drop_cnt  <= 8'd0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_SEND) begin
            r_gap_cnt <= GAP_LOAD;
         end else if (r_state == ST_GAP && r_gap_cnt != 4'd0) begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
         end
         // tx fields are zero except during the single SEND cycle.
         r_tx_valid  <= w_load;
         r_tx_source <= w_load ? SRC_ADDR : '0;
         r_tx_target <= w_load ? w_head_target : '0;
         r_tx_data   <= w_load ? w_head_data : '0;
         if (w_load) begin
            r_sent_cnt <= r_sent_cnt + 16'd1;
         end
         if (w_drop && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   assign req_ready = !w_fifo_full;
   assign busy      = (r_state != ST_IDLE) || !w_fifo_empty;
   assign tx_valid  = r_tx_valid;
   assign tx_source = r_tx_source;
   assign tx_target = r_tx_target;
   assign tx_data   = r_tx_data;
   assign sent_cnt  = r_sent_cnt;
   assign drop_cnt  = r_drop_cnt;

endmodule

// File: doc/port_tx.md
PORT_TX -- requirements
Module: port_tx

Interface
REQ-001 Parameter PORT_ID, default 0, index (0..3) of the switch port this transmitter drives; source address = one-hot 1<<PORT_ID.
REQ-002 Parameter FIFO_DEPTH, default 4, request queue entries (power of two, >=2).
REQ-003 Parameter GAP_CYCLES, default 2, minimum idle cycles between tx_valid pulses (0..15).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-high (1 = reset).
REQ-006 enable  in  1  permits popping new packets; 0 pauses the transmitter.
REQ-007 req_valid  in  1  host offers a packet.
REQ-008 req_ready  out  1  queue can accept the offered packet.
REQ-009 req_target  in  ADDR_WIDTH  one-hot destination port.
REQ-010 req_data  in  PAYLOAD_WIDTH  packet payload.
REQ-011 tx_valid  out  1  one-cycle packet strobe into the switch port valid_in.
REQ-012 tx_source  out  ADDR_WIDTH  to switch source_in.
REQ-013 tx_target  out  ADDR_WIDTH  to switch target_in.
REQ-014 tx_data  out  PAYLOAD_WIDTH  to switch data_in.
REQ-015 busy  out  1  state != IDLE or queue non-empty.
REQ-016 sent_cnt  out  16  packets transmitted.
REQ-017 drop_cnt  out  8  packets discarded as invalid.

Function
REQ-018 Push occurs when req_valid && req_ready; req_ready = !full, independent of req_valid and of a same-cycle pop (no bypass when full).
REQ-019 A push into an empty queue is not bypassed; earliest pop is the following cycle.
REQ-020 FSM states IDLE, SEND, GAP; a pop opportunity exists in IDLE, in the last GAP cycle, and in SEND when GAP_CYCLES=0.
REQ-021 At a pop opportunity with enable=1 and queue non-empty the head is popped; if valid, next state is SEND with registered tx_* loaded; if invalid, next state is IDLE and drop_cnt increments.
REQ-022 A head is invalid if req_target is not exactly one-hot or equals the own source bit.
REQ-023 SEND lasts exactly one cycle with tx_valid=1, tx_source=1<<PORT_ID, tx_target/tx_data from the popped entry; sent_cnt increments (wraps at 2^16).
REQ-024 After SEND: GAP for GAP_CYCLES cycles (tx_valid=0), else (GAP_CYCLES=0) pop opportunity directly; with no pop, go IDLE.
REQ-025 Latency: push at edge k into empty queue, idle FSM, enable=1 -> tx_valid high in the cycle after edge k+1.
REQ-026 Sustained traffic: tx_valid pulse period exactly GAP_CYCLES+1 cycles.
REQ-027 tx_source, tx_target, tx_data SHALL be 0 whenever tx_valid=0.
REQ-028 enable=0 blocks pops only; an in-progress SEND/GAP completes normally.
REQ-029 drop_cnt saturates at 255.
REQ-030 Simultaneous push and pop on a non-full queue both take effect; occupancy unchanged.

Reset
REQ-031 rst_n=1 at an edge: state IDLE, queue flushed, sent_cnt=0, drop_cnt=0, tx_* = 0, busy=0, req_ready=1 next cycle.
REQ-032 Reset mid-SEND or mid-GAP aborts; no tx_valid follows until new pushes after reset release.

Structure
REQ-033 packet_pkg holds ADDR_WIDTH (4), PAYLOAD_WIDTH (8), DATA_WIDTH (PAYLOAD_WIDTH+2*ADDR_WIDTH) and the tx state enum.
REQ-034 The request queue is one sub-module, tx_fifo (synchronous, full/empty flags, width ADDR_WIDTH+PAYLOAD_WIDTH).

Verification (PORT_ID=1, FIFO_DEPTH=4, GAP_CYCLES=2)
REQ-035 Reset held 3 cycles -> all outputs 0, req_ready=1.
REQ-036 Push target 4'b0100 data 8'hA5 at edge k -> cycle after edge k+1: tx_valid=1, tx_source=4'b0010, tx_target=4'b0100, tx_data=8'hA5; sent_cnt=1.
REQ-037 enable=0, push 5 consecutive packets -> 4 accepted, req_ready=0 on 5th; enable=1 -> 4 tx_valid pulses spaced 3 cycles, sent_cnt=4.
REQ-038 Push targets 4'b0010 and 4'b0110 -> no tx_valid, drop_cnt=2, sent_cnt unchanged.
REQ-039 Two packets queued, reset asserted during GAP after first SEND -> no further tx_valid, counters 0, busy=0.
REQ-040 GAP_CYCLES=0, 3 packets queued -> tx_valid high 3 consecutive cycles.
